sp_ram_fifo_ctrl: RTL

- Master-side controller that drives an 8-bit single-port block RAM port (ce/oce/wre/ad/din in, dout back) and presents it as a byte FIFO.
- Push side is valid/ready; pop side is valid/ready backed by a one-entry output register fed by RAM prefetch.
- Used as a deep byte buffer in the cpm68k design, e.g. between the 68k bus and a serial/console peripheral.

---
 rtl/sp_fifo_pkg.sv | 19 +
 rtl/sp_ram_fifo_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sp_fifo_pkg.sv
// Shared defaults and RAM port command encoding for the single-port RAM byte FIFO.
package sp_fifo_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;

  // Command presented to the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WR   = 2'd1,
    MEM_RD   = 2'd2
  } mem_cmd_e;

  // Number of RAM entries for a given address width.
  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl.sv
// Byte FIFO controller driving one single-port block RAM, with a one-entry
// prefetched output register on the pop side.
// Optional macro SPFIFO_BYPASS_EN: a push into a completely empty FIFO goes
// straight into the output register instead of through the RAM.
module sp_ram_fifo_ctrl
  import sp_fifo_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] level,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_reset,
  output logic          mem_wre,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned DEPTH = depth(AW);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned LW    = AW + 2;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic     full_c;
  logic     rd_go_c;
  logic     in_ready_c;
  logic     push_c;
  logic     pop_c;
  logic     byp_c;
  logic     wr_go_c;
  mem_cmd_e cmd_c;

  // Port arbitration: a refill read always takes the RAM ahead of a write.
  always_comb begin
    full_c     = (cnt_q == CW'(DEPTH));
    rd_go_c    = (cnt_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    in_ready_c = reset_n && !full_c && !rd_go_c;
    push_c     = in_valid && in_ready_c;
    pop_c      = out_valid_q && out_ready;
`ifdef SPFIFO_BYPASS_EN
    byp_c      = push_c && (cnt_q == '0) && !rd_pend_q && (!out_valid_q || out_ready);
`else
    byp_c      = 1'b0;
`endif
    wr_go_c    = push_c && !byp_c;
    if (rd_go_c) begin
      cmd_c = MEM_RD;
    end else if (wr_go_c) begin
      cmd_c = MEM_WR;
    end else begin
      cmd_c = MEM_IDLE;
    end
  end

  // RAM port mux; address and data are parked at zero when the port is idle.
  always_comb begin
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    mem_ad  = '0;
    mem_din = '0;
    case (cmd_c)
      MEM_RD: begin
        mem_ce = 1'b1;
        mem_ad = rd_ptr_q;
      end
      MEM_WR: begin
        mem_ce  = 1'b1;
        mem_wre = 1'b1;
        mem_ad  = wr_ptr_q;
        mem_din = in_data;
      end
      default: ;
    endcase
  end

  // Next-state for pointers, count and the output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rd_pend_d   = rd_go_c;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (wr_go_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + CW'(1);
    end
    if (rd_go_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q - CW'(1);
    end
    // A landing read only happens while the output register is empty.
    if (rd_pend_q) begin
      out_data_d  = mem_dout;
      out_valid_d = 1'b1;
    end else if (byp_c) begin
      out_data_d  = in_data;
      out_valid_d = 1'b1;
    end else if (pop_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = LW'(cnt_q) + LW'(rd_pend_q) + LW'(out_valid_q);
  assign mem_oce   = 1'b1;
  assign mem_reset = 1'b0;

endmodule
